// File: rtl/compare_pkg.sv
// rtl/compare_pkg.sv - shared types and helpers for the comparator scoreboard
package compare_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_A    = 2'b01;
    localparam logic [1:0] WIN_B    = 2'b10;

    // A well-formed comparator result raises exactly one of the three flags.
    function automatic logic isOneHot(input logic gtA, input logic gtB, input logic aeqB);
        logic ok;
        case ({gtA, gtB, aeqB})
            3'b100, 3'b010, 3'b001: ok = 1'b1;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/compare_scoreboard_if.sv
// rtl/compare_scoreboard_if.sv - comparator result handshake into the scoreboard
interface compare_scoreboard_if;

    logic in_valid;
    logic in_ready;
    logic gtA;
    logic gtB;
    logic AeqB;

    modport master (
        output in_valid,
        output gtA,
        output gtB,
        output AeqB,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  gtA,
        input  gtB,
        input  AeqB,
        output in_ready
    );

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter with synchronous clear that holds at all-ones
module sat_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/compare_scoreboard.sv
// rtl/compare_scoreboard.sv - tallies comparator results and declares a match winner
module compare_scoreboard
    import compare_pkg::*;
#(
    parameter int WIN_SCORE = 5,
    parameter int CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    compare_scoreboard_if.slave  inBus,
    output logic [CNT_W-1:0]     score_a,
    output logic [CNT_W-1:0]     score_b,
    output logic [CNT_W-1:0]     ties,
    output logic                 done,
    output logic [1:0]           winner,
    output logic                 err
);

    // Hitting this value before an increment means that increment wins the match.
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WIN_SCORE - 1);

    state_t     state;
    state_t     stateNext;
    logic       accept;
    logic       flagsOk;
    logic       clrAll;
    logic       incA;
    logic       incB;
    logic       incT;
    logic       setErr;
    logic       setWinner;
    logic [1:0] winnerNext;

    assign inBus.in_ready = (state == RUN);
    assign done           = (state == DONE);
    assign accept         = inBus.in_valid && (state == RUN);
    assign flagsOk        = isOneHot(inBus.gtA, inBus.gtB, inBus.AeqB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext  = state;
        clrAll     = 1'b0;
        incA       = 1'b0;
        incB       = 1'b0;
        incT       = 1'b0;
        setErr     = 1'b0;
        setWinner  = 1'b0;
        winnerNext = WIN_NONE;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    clrAll    = 1'b1;
                    stateNext = RUN;
                end
            end
            RUN: begin
                // A restart wins over a sample arriving in the same cycle.
                if (start) begin
                    clrAll = 1'b1;
                end else if (accept) begin
                    if (!flagsOk) begin
                        setErr = 1'b1;
                    end else if (inBus.gtA) begin
                        incA = 1'b1;
                        if (score_a == WIN_LAST) begin
                            stateNext  = DONE;
                            setWinner  = 1'b1;
                            winnerNext = WIN_A;
                        end
                    end else if (inBus.gtB) begin
                        incB = 1'b1;
                        if (score_b == WIN_LAST) begin
                            stateNext  = DONE;
                            setWinner  = 1'b1;
                            winnerNext = WIN_B;
                        end
                    end else begin
                        incT = 1'b1;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            winner <= WIN_NONE;
            err    <= 1'b0;
        end else if (clrAll) begin
            winner <= WIN_NONE;
            err    <= 1'b0;
        end else begin
            if (setWinner) begin
                winner <= winnerNext;
            end
            if (setErr) begin
                err <= 1'b1;
            end
        end
    end

    sat_counter #(.WIDTH(CNT_W)) uScoreA (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clrAll),
        .inc   (incA),
        .count (score_a)
    );

    sat_counter #(.WIDTH(CNT_W)) uScoreB (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clrAll),
        .inc   (incB),
        .count (score_b)
    );

    sat_counter #(.WIDTH(CNT_W)) uTies (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clrAll),
        .inc   (incT),
        .count (ties)
    );

endmodule

// File: tb/tb_compare_scoreboard.sv
// tb/tb_compare_scoreboard.sv - directed self-checking bench for compare_scoreboard
module tb_compare_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       start2;
    logic [3:0] score_a, score_b, ties;
    logic       done;
    logic [1:0] winner;
    logic       err;
    logic [1:0] score_a2, score_b2, ties2;
    logic       done2;
    logic [1:0] winner2;
    logic       err2;
    int         passCount = 0;
    int         checkCount = 0;

    compare_scoreboard_if bus();
    compare_scoreboard_if bus2();

    compare_scoreboard #(.WIN_SCORE(5), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .inBus(bus.slave),
        .score_a(score_a), .score_b(score_b), .ties(ties),
        .done(done), .winner(winner), .err(err)
    );

    compare_scoreboard #(.WIN_SCORE(3), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .inBus(bus2.slave),
        .score_a(score_a2), .score_b(score_b2), .ties(ties2),
        .done(done2), .winner(winner2), .err(err2)
    );

    always #5 clk = ~clk;

    task automatic setFlags(input logic v, input logic [2:0] f);
        bus.in_valid = v;
        {bus.gtA, bus.gtB, bus.AeqB} = f;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        setFlags(1'b0, 3'b000);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checkCount++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready got %0b expected 0", bus.in_ready); else passCount++;
        checkCount++; if ({score_a, score_b, ties} !== 12'd0) $display("FAIL reset_counters got %0h expected 0", {score_a, score_b, ties}); else passCount++;
        checkCount++; if ({done, winner, err} !== 4'd0) $display("FAIL reset_flags got %0b expected 0000", {done, winner, err}); else passCount++;
        @(negedge clk);
        rst_n = 1'b1;
        setFlags(1'b1, 3'b100);
        repeat (2) @(negedge clk);
        checkCount++; if (score_a !== 4'd0 || bus.in_ready !== 1'b0) $display("FAIL idle_ignores_valid got score_a=%0d in_ready=%0b expected 0/0", score_a, bus.in_ready); else passCount++;
    endtask

    task automatic test_back_to_back();
        pulseStart();
        checkCount++; if (bus.in_ready !== 1'b1 || score_a !== 4'd0) $display("FAIL start_to_run got in_ready=%0b score_a=%0d expected 1/0", bus.in_ready, score_a); else passCount++;
        setFlags(1'b1, 3'b100);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            checkCount++; if (score_a !== 4'(i)) $display("FAIL b2b_score_a[%0d] got %0d expected %0d", i, score_a, i); else passCount++;
            checkCount++; if (done !== (i == 5)) $display("FAIL b2b_done[%0d] got %0b expected %0b", i, done, (i == 5)); else passCount++;
        end
        checkCount++; if (winner !== 2'b01 || bus.in_ready !== 1'b0) $display("FAIL b2b_win got winner=%0b in_ready=%0b expected 01/0", winner, bus.in_ready); else passCount++;
        @(negedge clk);
        checkCount++; if (score_a !== 4'd5 || done !== 1'b1) $display("FAIL b2b_frozen got score_a=%0d done=%0b expected 5/1", score_a, done); else passCount++;
        setFlags(1'b0, 3'b000);
    endtask

    task automatic test_interleave();
        logic [2:0] seq [12] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b001, 3'b001,
                                 3'b001, 3'b100, 3'b100, 3'b100, 3'b100, 3'b010};
        pulseStart();
        checkCount++; if ({score_a, done, winner} !== 7'd0) $display("FAIL restart_from_done got %0h expected 0", {score_a, done, winner}); else passCount++;
        for (int i = 0; i < 12; i++) begin
            setFlags(1'b1, seq[i]);
            @(negedge clk);
            if (i == 10) begin
                checkCount++; if (done !== 1'b0) $display("FAIL mix_early_done got %0b expected 0", done); else passCount++;
            end
        end
        setFlags(1'b0, 3'b000);
        checkCount++; if (done !== 1'b1 || winner !== 2'b10) $display("FAIL mix_winner got done=%0b winner=%0b expected 1/10", done, winner); else passCount++;
        checkCount++; if (score_a !== 4'd4 || score_b !== 4'd5 || ties !== 4'd3) $display("FAIL mix_scores got %0d/%0d/%0d expected 4/5/3", score_a, score_b, ties); else passCount++;
    endtask

    task automatic test_error();
        pulseStart();
        setFlags(1'b1, 3'b011);
        @(negedge clk);
        checkCount++; if (err !== 1'b1 || {score_a, score_b, ties} !== 12'd0) $display("FAIL err_011 got err=%0b counters=%0h expected 1/0", err, {score_a, score_b, ties}); else passCount++;
        setFlags(1'b1, 3'b000);
        @(negedge clk);
        checkCount++; if (err !== 1'b1 || {score_a, score_b, ties} !== 12'd0) $display("FAIL err_000 got err=%0b counters=%0h expected 1/0", err, {score_a, score_b, ties}); else passCount++;
        setFlags(1'b1, 3'b100);
        @(negedge clk);
        checkCount++; if (err !== 1'b1 || score_a !== 4'd1) $display("FAIL err_sticky got err=%0b score_a=%0d expected 1/1", err, score_a); else passCount++;
        pulseStart();
        checkCount++; if (err !== 1'b0) $display("FAIL err_clear got %0b expected 0", err); else passCount++;
    endtask

    task automatic test_start_priority();
        pulseStart();
        setFlags(1'b1, 3'b100);
        repeat (2) @(negedge clk);
        checkCount++; if (score_a !== 4'd2) $display("FAIL prio_pre got %0d expected 2", score_a); else passCount++;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkCount++; if (score_a !== 4'd0 || bus.in_ready !== 1'b1 || done !== 1'b0) $display("FAIL prio_clear got score_a=%0d in_ready=%0b done=%0b expected 0/1/0", score_a, bus.in_ready, done); else passCount++;
        @(negedge clk);
        checkCount++; if (score_a !== 4'd1) $display("FAIL prio_resume got %0d expected 1", score_a); else passCount++;
        setFlags(1'b0, 3'b000);
    endtask

    task automatic test_saturate();
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        bus2.in_valid = 1'b1;
        {bus2.gtA, bus2.gtB, bus2.AeqB} = 3'b001;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            checkCount++; if (ties2 !== 2'((i < 3) ? i : 3)) $display("FAIL sat_ties[%0d] got %0d expected %0d", i, ties2, (i < 3) ? i : 3); else passCount++;
        end
        bus2.in_valid = 1'b0;
        checkCount++; if (done2 !== 1'b0 || bus2.in_ready !== 1'b1 || winner2 !== 2'b00) $display("FAIL sat_no_done got done=%0b in_ready=%0b winner=%0b expected 0/1/00", done2, bus2.in_ready, winner2); else passCount++;
    endtask

    task automatic test_reset_mid_match();
        pulseStart();
        setFlags(1'b1, 3'b000);
        @(negedge clk);
        setFlags(1'b1, 3'b100);
        repeat (3) @(negedge clk);
        setFlags(1'b0, 3'b000);
        checkCount++; if (score_a !== 4'd3 || err !== 1'b1) $display("FAIL mid_pre got score_a=%0d err=%0b expected 3/1", score_a, err); else passCount++;
        #1 rst_n = 1'b0;
        #1;
        checkCount++; if (score_a !== 4'd0 || err !== 1'b0 || bus.in_ready !== 1'b0) $display("FAIL mid_async got score_a=%0d err=%0b in_ready=%0b expected 0/0/0", score_a, err, bus.in_ready); else passCount++;
        checkCount++; if ({score_b, ties, done, winner} !== 11'd0) $display("FAIL mid_async_rest got %0h expected 0", {score_b, ties, done, winner}); else passCount++;
        @(negedge clk);
        rst_n = 1'b1;
        setFlags(1'b1, 3'b100);
        repeat (2) @(negedge clk);
        checkCount++; if (score_a !== 4'd0 || bus.in_ready !== 1'b0) $display("FAIL mid_stays_idle got score_a=%0d in_ready=%0b expected 0/0", score_a, bus.in_ready); else passCount++;
        setFlags(1'b0, 3'b000);
    endtask

    initial begin
        start = 1'b0;
        start2 = 1'b0;
        bus2.in_valid = 1'b0;
        {bus2.gtA, bus2.gtB, bus2.AeqB} = 3'b000;
        setFlags(1'b0, 3'b000);
        test_reset();
        test_back_to_back();
        test_interleave();
        test_error();
        test_start_priority();
        test_saturate();
        test_reset_mid_match();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
